// File: rtl/fpu_pipe_pkg.sv
// Shared defaults and helpers for the FPU elastic pipeline registers.
package fpu_pipe_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TAG_WIDTH  = 4;
    localparam int DEF_PIPE_LEN   = 3;

    // Width needed to count 0..n valid stages.
    function automatic int clog2_occ(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fpu_pipe_slot.sv
// One stage of the elastic pipe: valid bit plus payload and tag, loaded on advance.
module fpu_pipe_slot
    import fpu_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_nreset,
    input  logic                  i_flush,
    input  logic                  i_adv,
    input  logic                  i_in_valid,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    input  logic [TAG_WIDTH-1:0]  i_in_tag,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [TAG_WIDTH-1:0]  o_tag
);

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
    } pipe_ctl_t;

    pipe_ctl_t             r_ctl;
    logic [DATA_WIDTH-1:0] r_data;

    // Flush wins over advance and leaves payload/tag untouched.
    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            r_ctl  <= '0;
            r_data <= '0;
        end else if (i_flush) begin
            r_ctl.valid <= 1'b0;
        end else if (i_adv) begin
            r_ctl.valid <= i_in_valid;
            if (i_in_valid) begin
                r_ctl.tag <= i_in_tag;
                r_data    <= i_in_data;
            end
        end
    end

    assign o_valid = r_ctl.valid;
    assign o_data  = r_data;
    assign o_tag   = r_ctl.tag;

endmodule

// File: rtl/fpu_elastic_pipe.sv
// N-stage valid/ready pipeline register with optional bubble collapsing, flush and tag sideband.
module fpu_elastic_pipe
    import fpu_pipe_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH       = DEF_TAG_WIDTH,
    parameter int PIPE_LEN        = DEF_PIPE_LEN,
    parameter int BUBBLE_COLLAPSE = 1
) (
    input  logic                            I_Clk,
    input  logic                            I_nReset,
    input  logic                            I_Flush,
    input  logic                            I_Valid,
    output logic                            O_Ready,
    input  logic [DATA_WIDTH-1:0]           I_D,
    input  logic [TAG_WIDTH-1:0]            I_Tag,
    output logic                            O_Valid,
    input  logic                            I_Ready,
    output logic [DATA_WIDTH-1:0]           O_Q,
    output logic [TAG_WIDTH-1:0]            O_Tag,
    output logic [$clog2(PIPE_LEN+1)-1:0]   O_Occupancy
);

    localparam int OCC_W = clog2_occ(PIPE_LEN);

    logic [PIPE_LEN:0]     w_adv;
    logic [PIPE_LEN-1:0]   w_valid;
    logic [DATA_WIDTH-1:0] w_data [PIPE_LEN];
    logic [TAG_WIDTH-1:0]  w_tag  [PIPE_LEN];
    logic [OCC_W-1:0]      w_occ;

    assign w_adv[PIPE_LEN] = I_Ready;

    genvar k;
    generate
        for (k = 0; k < PIPE_LEN; k++) begin : g_stage
            logic                  w_in_valid;
            logic [DATA_WIDTH-1:0] w_in_data;
            logic [TAG_WIDTH-1:0]  w_in_tag;

            if (k == 0) begin : g_head
                assign w_in_valid = I_Valid;
                assign w_in_data  = I_D;
                assign w_in_tag   = I_Tag;
            end else begin : g_body
                assign w_in_valid = w_valid[k-1];
                assign w_in_data  = w_data[k-1];
                assign w_in_tag   = w_tag[k-1];
            end

            // Elastic: an empty stage may always load. Lock-step: every stage follows I_Ready.
            if (BUBBLE_COLLAPSE != 0) begin : g_elastic
                assign w_adv[k] = ~w_valid[k] | w_adv[k+1];
            end else begin : g_lockstep
                assign w_adv[k] = w_adv[k+1];
            end

            fpu_pipe_slot #(
                .DATA_WIDTH (DATA_WIDTH),
                .TAG_WIDTH  (TAG_WIDTH)
            ) u_slot (
                .i_clk      (I_Clk),
                .i_nreset   (I_nReset),
                .i_flush    (I_Flush),
                .i_adv      (w_adv[k]),
                .i_in_valid (w_in_valid),
                .i_in_data  (w_in_data),
                .i_in_tag   (w_in_tag),
                .o_valid    (w_valid[k]),
                .o_data     (w_data[k]),
                .o_tag      (w_tag[k])
            );
        end
    endgenerate

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < PIPE_LEN; i++) begin
            w_occ = w_occ + OCC_W'(w_valid[i]);
        end
    end

    assign O_Ready     = w_adv[0];
    assign O_Valid     = w_valid[PIPE_LEN-1];
    assign O_Q         = w_data[PIPE_LEN-1];
    assign O_Tag       = w_tag[PIPE_LEN-1];
    assign O_Occupancy = w_occ;

endmodule

// File: tb/tb_fpu_elastic_pipe.sv
// Bench for fpu_elastic_pipe: four instances (L3 elastic, L3 lock-step, L1 and L4 elastic) on shared stimulus.
module tb_fpu_elastic_pipe;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        vin   = 1'b0;
    logic        rdy   = 1'b0;
    logic [31:0] din   = '0;
    logic [3:0]  tin   = '0;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        ov   [4];
    logic        ordy [4];
    logic [31:0] oq   [4];
    logic [3:0]  ot   [4];
    logic [2:0]  occ  [4];
    logic [1:0]  occ_a;
    logic [1:0]  occ_b;
    logic [0:0]  occ_c;
    logic [2:0]  occ_d;

    assign occ[0] = {1'b0, occ_a};
    assign occ[1] = {1'b0, occ_b};
    assign occ[2] = {2'b0, occ_c};
    assign occ[3] = occ_d;

    // Scoreboard: one in-order FIFO of {data,tag} per instance
    logic [35:0] sb_mem [4][64];
    int          wp [4];
    int          rp [4];
    logic        pv_hold [4];
    logic [31:0] pv_q [4];
    logic [3:0]  pv_t [4];

    fpu_elastic_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(4), .PIPE_LEN(3), .BUBBLE_COLLAPSE(1)) u_a (
        .I_Clk(clk), .I_nReset(rst_n), .I_Flush(flush), .I_Valid(vin), .O_Ready(ordy[0]),
        .I_D(din), .I_Tag(tin), .O_Valid(ov[0]), .I_Ready(rdy), .O_Q(oq[0]), .O_Tag(ot[0]),
        .O_Occupancy(occ_a));

    fpu_elastic_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(4), .PIPE_LEN(3), .BUBBLE_COLLAPSE(0)) u_b (
        .I_Clk(clk), .I_nReset(rst_n), .I_Flush(flush), .I_Valid(vin), .O_Ready(ordy[1]),
        .I_D(din), .I_Tag(tin), .O_Valid(ov[1]), .I_Ready(rdy), .O_Q(oq[1]), .O_Tag(ot[1]),
        .O_Occupancy(occ_b));

    fpu_elastic_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(4), .PIPE_LEN(1), .BUBBLE_COLLAPSE(1)) u_c (
        .I_Clk(clk), .I_nReset(rst_n), .I_Flush(flush), .I_Valid(vin), .O_Ready(ordy[2]),
        .I_D(din), .I_Tag(tin), .O_Valid(ov[2]), .I_Ready(rdy), .O_Q(oq[2]), .O_Tag(ot[2]),
        .O_Occupancy(occ_c));

    fpu_elastic_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(4), .PIPE_LEN(4), .BUBBLE_COLLAPSE(1)) u_d (
        .I_Clk(clk), .I_nReset(rst_n), .I_Flush(flush), .I_Valid(vin), .O_Ready(ordy[3]),
        .I_D(din), .I_Tag(tin), .O_Valid(ov[3]), .I_Ready(rdy), .O_Q(oq[3]), .O_Tag(ot[3]),
        .O_Occupancy(occ_d));

    function automatic int len_of(input int i);
        case (i)
            2:       return 1;
            3:       return 4;
            default: return 3;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; flush = 1'b0; vin = 1'b0; rdy = 1'b0; din = '0; tin = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wp[i] = 0; rp[i] = 0; pv_hold[i] = 1'b0; pv_q[i] = '0; pv_t[i] = '0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if (ov[0] !== 1'b0 || oq[0] !== 32'h0 || ot[0] !== 4'h0 || occ[0] !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%0b q=%h tag=%h occ=%0d, expected all zero", ov[0], oq[0], ot[0], occ[0]);
        end
        n_tests++;
        if (ordy[0] !== 1'b1 || ordy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got elastic=%0b lockstep=%0b, expected 1 and 0", ordy[0], ordy[1]);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vin = 1'b1; din = 32'hC0 + 32'(c); tin = 4'(c); rdy = 1'b0;
        end
        @(negedge clk);
        vin = 1'b0;
        n_tests++;
        if (occ[0] !== 3'd3) begin
            n_fail++;
            $display("FAIL reset_prefill_occ: got %0d, expected 3", occ[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (ov[0] !== 1'b0 || oq[0] !== 32'h0 || ot[0] !== 4'h0 || occ[0] !== 3'd0 || occ[3] !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_midstall: got v=%0b q=%h tag=%h occ=%0d occ4=%0d, expected all zero",
                     ov[0], oq[0], ot[0], occ[0], occ[3]);
        end
        @(negedge clk);
        rst_n = 1'b1; rdy = 1'b0;
        #1;
        n_tests++;
        if (ordy[0] !== 1'b1 || ordy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready: got elastic=%0b lockstep=%0b, expected 1 and 0", ordy[0], ordy[1]);
        end
        rdy = 1'b1;
        #1;
        n_tests++;
        if (ordy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL lockstep_ready_follows: got %0b, expected 1", ordy[1]);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            n_tests++;
            if (c < 3) begin
                if (ov[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_latency c=%0d: got v=%0b, expected 0", c, ov[0]);
                end
            end else if (ov[0] !== 1'b1 || oq[0] !== 32'(c - 2)) begin
                n_fail++;
                $display("FAIL stream_q c=%0d: got v=%0b q=%0h, expected v=1 q=%0h", c, ov[0], oq[0], c - 2);
            end
            if (c >= 3 && c <= 10) begin
                n_tests++;
                if (occ[0] !== 3'd3) begin
                    n_fail++;
                    $display("FAIL stream_occ c=%0d: got %0d, expected 3", c, occ[0]);
                end
            end
            vin = (c < 10); din = 32'(c + 1); tin = 4'(c); rdy = 1'b1;
        end
    endtask

    task automatic test_collapse();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 4) begin
                n_tests++;
                if (occ[0] !== 3'd2 || ov[0] !== 1'b1 || oq[0] !== 32'hA0) begin
                    n_fail++;
                    $display("FAIL collapse_pack: got occ=%0d v=%0b q=%h, expected occ=2 v=1 q=a0", occ[0], ov[0], oq[0]);
                end
            end
            if (c == 5) begin
                n_tests++;
                if (occ[0] !== 3'd3) begin
                    n_fail++;
                    $display("FAIL collapse_full: got occ=%0d, expected 3", occ[0]);
                end
            end
            if (c >= 6 && c <= 8) begin
                n_tests++;
                if (ov[0] !== 1'b1 || oq[0] !== 32'hA0 + 32'(c - 6) || ot[0] !== 4'(c - 5)) begin
                    n_fail++;
                    $display("FAIL collapse_drain c=%0d: got v=%0b q=%h tag=%0d, expected v=1 q=%h tag=%0d",
                             c, ov[0], oq[0], ot[0], 32'hA0 + 32'(c - 6), c - 5);
                end
            end
            if (c == 9) begin
                n_tests++;
                if (ov[0] !== 1'b0 || occ[0] !== 3'd0) begin
                    n_fail++;
                    $display("FAIL collapse_empty: got v=%0b occ=%0d, expected 0 0", ov[0], occ[0]);
                end
            end
            vin = (c == 0 || c == 2 || c == 4);
            din = (c == 0) ? 32'hA0 : (c == 2) ? 32'hA1 : 32'hA2;
            tin = (c == 0) ? 4'd1 : (c == 2) ? 4'd2 : 4'd3;
            rdy = (c >= 6);
            #1;
            if (c == 4 || c == 5) begin
                n_tests++;
                if (ordy[0] !== (c == 4)) begin
                    n_fail++;
                    $display("FAIL collapse_ready c=%0d: got %0b, expected %0b", c, ordy[0], c == 4);
                end
            end
        end
    endtask

    task automatic test_lockstep();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 3 && c <= 6) begin
                n_tests++;
                if (ov[1] !== 1'b1 || oq[1] !== 32'hA0 || occ[1] !== 3'd2) begin
                    n_fail++;
                    $display("FAIL lockstep_freeze c=%0d: got v=%0b q=%h occ=%0d, expected v=1 q=a0 occ=2",
                             c, ov[1], oq[1], occ[1]);
                end
            end
            if (c == 7 || c == 9) begin
                n_tests++;
                if (ov[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lockstep_bubble c=%0d: got v=%0b, expected 0", c, ov[1]);
                end
            end
            if (c == 8) begin
                n_tests++;
                if (ov[1] !== 1'b1 || oq[1] !== 32'hA1) begin
                    n_fail++;
                    $display("FAIL lockstep_second: got v=%0b q=%h, expected v=1 q=a1", ov[1], oq[1]);
                end
            end
            vin = (c == 0 || c == 2 || (c >= 3 && c <= 5));
            din = (c == 0) ? 32'hA0 : (c == 2) ? 32'hA1 : 32'hA2;
            tin = 4'(c);
            rdy = !(c >= 3 && c <= 5);
            #1;
            if (c >= 3 && c <= 5) begin
                n_tests++;
                if (ordy[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lockstep_ready c=%0d: got %0b, expected 0", c, ordy[1]);
                end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 3) begin
                n_tests++;
                if (occ[0] !== 3'd3 || ov[0] !== 1'b1 || oq[0] !== 32'hB0) begin
                    n_fail++;
                    $display("FAIL flush_prefill: got occ=%0d v=%0b q=%h, expected 3 1 b0", occ[0], ov[0], oq[0]);
                end
            end
            if (c == 4) begin
                n_tests++;
                if (occ[0] !== 3'd0 || ov[0] !== 1'b0 || oq[0] !== 32'hB0) begin
                    n_fail++;
                    $display("FAIL flush_clear: got occ=%0d v=%0b q=%h, expected 0 0 b0", occ[0], ov[0], oq[0]);
                end
            end
            if (c > 4) begin
                n_tests++;
                if (ov[0] !== 1'b0 || oq[0] === 32'h55) begin
                    n_fail++;
                    $display("FAIL flush_discard c=%0d: got v=%0b q=%h, expected v=0 and never 55", c, ov[0], oq[0]);
                end
            end
            flush = (c == 3);
            vin   = (c <= 3);
            din   = (c == 3) ? 32'h55 : 32'hB0 + 32'(c);
            tin   = 4'(c);
            rdy   = 1'b1;
        end
        flush = 1'b0;
    endtask

    task automatic test_random();
        int   idx [3];
        int   i;
        int   cnt;
        logic exp_rdy;
        idx[0] = 0; idx[1] = 2; idx[2] = 3;
        do_reset();
        for (int cyc = 0; cyc < 700; cyc++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                i = idx[j];
                n_tests++;
                if (occ[i] !== 3'(wp[i] - rp[i])) begin
                    n_fail++;
                    $display("FAIL rand_occ L=%0d cyc=%0d: got %0d, expected %0d", len_of(i), cyc, occ[i], wp[i] - rp[i]);
                end
                if (pv_hold[i]) begin
                    n_tests++;
                    if (ov[i] !== 1'b1 || oq[i] !== pv_q[i] || ot[i] !== pv_t[i]) begin
                        n_fail++;
                        $display("FAIL rand_stable L=%0d cyc=%0d: got v=%0b q=%h tag=%h, expected v=1 q=%h tag=%h",
                                 len_of(i), cyc, ov[i], oq[i], ot[i], pv_q[i], pv_t[i]);
                    end
                end
            end
            if (cyc < 680) begin
                vin = 1'($urandom_range(0, 1));
                rdy = 1'($urandom_range(0, 1));
            end else begin
                vin = 1'b0;
                rdy = 1'b1;
            end
            din = $urandom;
            tin = 4'(cyc);
            #1;
            for (int j = 0; j < 3; j++) begin
                i = idx[j];
                cnt = wp[i] - rp[i];
                exp_rdy = (cnt < len_of(i)) || rdy;
                n_tests++;
                if (ordy[i] !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL rand_ready L=%0d cyc=%0d: got %0b, expected %0b", len_of(i), cyc, ordy[i], exp_rdy);
                end
                if (ov[i] === 1'b1 && cnt == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rand_spurious L=%0d cyc=%0d: got valid with q=%h, expected nothing in flight",
                             len_of(i), cyc, oq[i]);
                end else if (ov[i] === 1'b1 && rdy) begin
                    n_tests++;
                    if ({oq[i], ot[i]} !== sb_mem[i][rp[i] & 63]) begin
                        n_fail++;
                        $display("FAIL rand_order L=%0d cyc=%0d: got %h, expected %h",
                                 len_of(i), cyc, {oq[i], ot[i]}, sb_mem[i][rp[i] & 63]);
                    end
                    rp[i]++;
                end
                if (vin && ordy[i] === 1'b1) begin
                    sb_mem[i][wp[i] & 63] = {din, tin};
                    wp[i]++;
                end
                pv_hold[i] = (ov[i] === 1'b1) && !rdy;
                pv_q[i]    = oq[i];
                pv_t[i]    = ot[i];
            end
        end
        for (int j = 0; j < 3; j++) begin
            i = idx[j];
            n_tests++;
            if (wp[i] != rp[i]) begin
                n_fail++;
                $display("FAIL rand_drain L=%0d: got %0d items undelivered, expected 0", len_of(i), wp[i] - rp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_collapse();
        test_lockstep();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
